// File: rtl/uart_transmit.sv
// UART transmitter: 1-entry holding buffer feeding an 8N1 LSB-first shifter, paced by b_en.
// Optional even parity bit (8E1) when UART_TX_PARITY_EN is defined.
module uart_transmit #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_en,
    input  logic              i_iocs,
    input  logic              i_iorw,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_tx,
    output logic              o_tbr,
    output logic              o_busy
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif

    logic [2:0]        state, state_nxt;
    logic [TICK_W-1:0] tick, tick_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [DATA_W-1:0] hold, hold_nxt;
    logic              tx_nxt, tbr_nxt, busy_nxt;
    logic              load;
    logic              wr_c;
    logic              bit_end_c;
`ifdef UART_TX_PARITY_EN
    logic              parity, parity_nxt;
`endif

    // o_tbr doubles as the "holding buffer empty" flag
    assign wr_c      = i_iocs & ~i_iorw & o_tbr;
    assign bit_end_c = b_en && (tick == TICK_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            hold    <= '0;
            o_tx    <= 1'b1;
            o_tbr   <= 1'b1;
            o_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            hold    <= hold_nxt;
            o_tx    <= tx_nxt;
            o_tbr   <= tbr_nxt;
            o_busy  <= busy_nxt;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        hold_nxt  = hold;
        tx_nxt    = o_tx;
        tbr_nxt   = o_tbr;
        busy_nxt  = o_busy;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity;
`endif

        if (wr_c) begin
            hold_nxt = i_data;
            tbr_nxt  = 1'b0;
        end

        if ((state != IDLE) && b_en) begin
            tick_nxt = bit_end_c ? '0 : tick + TICK_W'(1);
        end

        case (state)
            IDLE: begin
                if (!o_tbr) load = 1'b1;
            end
            START: begin
                if (bit_end_c) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = parity;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                        tx_nxt  = shift_nxt[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end_c) begin
                    if (!o_tbr) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        // Buffer-to-shifter transfer; never coincides with an accepted write
        if (load) begin
            shift_nxt = hold;
            tbr_nxt   = 1'b1;
            state_nxt = START;
            tx_nxt    = 1'b0;
            busy_nxt  = 1'b1;
            tick_nxt  = '0;
`ifdef UART_TX_PARITY_EN
            parity_nxt = ^hold;
`endif
        end
    end

endmodule
